// File: rtl/res_readback.sv
// res_readback: streams pooling results out of the four result RAMs.
// Each beat packs one address's bytes as {res_q0, res_q1, res_q2, res_q3}.
// Reads run ahead of the consumer into a 2-entry skid FIFO, so a consumer that
// is always ready receives one word per cycle.
// Optional feature: define READBACK_CHECKSUM_EN to add a 16-bit byte-sum
// checksum of all delivered beats on output port csum.
module res_readback #(
    parameter int ADDR_W  = 11,
    parameter int LEN_W   = 12,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              res_rd_en,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [7:0]        res_q0,
    input  logic [7:0]        res_q1,
    input  logic [7:0]        res_q2,
    input  logic [7:0]        res_q3,
    output logic [31:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
`ifdef READBACK_CHECKSUM_EN
    ,
    output logic [15:0]       csum
`endif
);

    // The capture logic assumes read data lands exactly one cycle after the strobe.
    if (RAM_LAT != 1) begin : g_lat_check
        $error("res_readback: only RAM_LAT == 1 is supported");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [31:0]       fifo_q [2];
    logic [31:0]       fifo_d [2];

    logic              push;
    logic              pop;
    logic              start_ok;
    logic [2:0]        occupancy;

    // Handshake terms and the read-issue window.
    always_comb begin
        dout_valid = (count_q != 2'd0);
        push       = inflight_q;
        pop        = dout_valid && dout_ready;
        start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        occupancy  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        res_rd_en  = (state_q == S_FETCH) && (remaining_q != '0) && (occupancy < 3'd2);
        res_addr   = addr_q;
        dout       = dout_valid ? fifo_q[rd_ptr_q] : 32'h0;
        busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
        done       = (state_q == S_DONE);
    end

    // Next-state, address/length bookkeeping and FIFO pointer updates.
    always_comb begin
        // NOTE: every *_d takes its hold value first, so no branch below can leave one unassigned and infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_d      = fifo_q;
        inflight_d  = res_rd_en;

        if (push) begin
            fifo_d[wr_ptr_q] = {res_q0, res_q1, res_q2, res_q3};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);

        if (res_rd_en) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    if (length != '0) begin
                        addr_d      = base_addr;
                        remaining_d = length;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (res_rd_en && (remaining_q == LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look at next-cycle occupancy so done rises right after the last accept.
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbours.
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; dout is gated by dout_valid, so stale entries are never visible.
        fifo_q <= fifo_d;
    end

`ifdef READBACK_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Running byte-sum of every accepted beat, cleared when a readback starts.
    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = 16'h0;
        end else if (pop) begin
            csum_d = csum_q + 16'(dout[31:24]) + 16'(dout[23:16])
                            + 16'(dout[15:8])  + 16'(dout[7:0]);
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 16'h0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_res_readback.sv
// tb_res_readback: table-driven readback transfers with a word/address
// scoreboard, plus hand-written reset-abort and optional checksum sequences.
module tb_res_readback;

    localparam int ADDR_W = 11;
    localparam int LEN_W  = 12;
    localparam int DEPTH  = 2048;
    localparam int BUDGET = 2000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              res_rd_en;
    logic [ADDR_W-1:0] res_addr;
    logic [7:0]        res_q0, res_q1, res_q2, res_q3;
    logic [31:0]       dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
`ifdef READBACK_CHECKSUM_EN
    logic [15:0]       csum;
`endif

    always #5 clk = ~clk;

    res_readback #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RAM_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .res_rd_en  (res_rd_en),
        .res_addr   (res_addr),
        .res_q0     (res_q0),
        .res_q1     (res_q1),
        .res_q2     (res_q2),
        .res_q3     (res_q3),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
`ifdef READBACK_CHECKSUM_EN
        ,
        .csum       (csum)
`endif
    );

    // Result RAM model: one-cycle read latency.
    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];
    logic [7:0] mem2 [DEPTH];
    logic [7:0] mem3 [DEPTH];

    always @(posedge clk) begin
        if (res_rd_en) begin
            res_q0 <= mem0[res_addr];
            res_q1 <= mem1[res_addr];
            res_q2 <= mem2[res_addr];
            res_q3 <= mem3[res_addr];
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        int                mode;       // 0: ready=1, 1: ready 1,0,0,1, 2: random
        int                exp_first;  // cycles from start to first dout_valid (0: none expected)
        int                exp_done;   // cycles from start to done (0: not checked)
        bit                poke;       // pulse a second start while busy
    } vec_t;

    vec_t vecs [6];

    logic [31:0]       exp_words [$];
    logic [ADDR_W-1:0] exp_addrs [$];

    int          checks       = 0;
    int          failures     = 0;
    int          issued_cnt   = 0;
    int          accepted_cnt = 0;
    logic        prev_hold    = 1'b0;
    logic [31:0] prev_dout    = 32'h0;
    logic        mon_pop;
    logic [31:0]       mon_word;
    logic [ADDR_W-1:0] mon_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {mem0[a], mem1[a], mem2[a], mem3[a]};
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Monitor: scoreboard pops, issue-window and backpressure-hold checks.
    always @(negedge clk) begin
        if (!reset) begin
            mon_pop = dout_valid && dout_ready;
            if (prev_hold) begin
                check("hold_valid", 32'(dout_valid), 32'd1);
                check("hold_data", dout, prev_dout);
            end
            if (res_rd_en) begin
                check("rd_within_window", 32'((issued_cnt - accepted_cnt - int'(mon_pop)) < 2), 32'd1);
                check("rd_expected", 32'(exp_addrs.size() != 0), 32'd1);
                if (exp_addrs.size() != 0) begin
                    mon_addr = exp_addrs.pop_front();
                    check("rd_addr", 32'(res_addr), 32'(mon_addr));
                end
            end
            if (mon_pop) begin
                check("beat_expected", 32'(exp_words.size() != 0), 32'd1);
                if (exp_words.size() != 0) begin
                    mon_word = exp_words.pop_front();
                    check("beat_data", dout, mon_word);
                end
            end
            issued_cnt   += int'(res_rd_en);
            accepted_cnt += int'(mon_pop);
            prev_hold     = dout_valid && !dout_ready;
            prev_dout     = dout;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(res_rd_en), 32'd0);
        check({tag, "_addr"}, 32'(res_addr), 32'd0);
        check({tag, "_dout"}, dout, 32'h0);
        check({tag, "_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic load_expect(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        for (int a = 0; a < int'(len); a++) begin
            exp_words.push_back(model_word((int'(base) + a) % DEPTH));
            exp_addrs.push_back(ADDR_W'((int'(base) + a) % DEPTH));
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int first_k = -1;
        int done_k  = -1;
        int iss0    = issued_cnt;
        int acc0    = accepted_cnt;
        load_expect(v.base, v.len);
        start      = 1'b1;
        base_addr  = v.base;
        length     = v.len;
        dout_ready = ready_for(v.mode, 0);
        for (int k = 1; k <= BUDGET; k++) begin
            tick();
            start = 1'b0;
            if (v.poke && (k == 2)) begin
                start     = 1'b1;
                base_addr = 11'd900;
                length    = 12'd3;
            end
            dout_ready = ready_for(v.mode, k);
            if ((first_k < 0) && dout_valid) first_k = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done_k >= 0), 32'd1);
        if (v.exp_done != 0) check("done_latency", 32'(done_k), 32'(v.exp_done));
        if (v.exp_first != 0) check("first_latency", 32'(first_k), 32'(v.exp_first));
        else check("no_valid", 32'(first_k < 0), 32'd1);
        check("reads_issued", 32'(issued_cnt - iss0), 32'(v.len));
        check("beats_accepted", 32'(accepted_cnt - acc0), 32'(v.len));
        check("words_left", 32'(exp_words.size()), 32'd0);
        check("addrs_left", 32'(exp_addrs.size()), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_valid", 32'(dout_valid), 32'd0);
    endtask

    initial begin
        vec_t cv;
        int   acc0;
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = 8'(i);
            mem1[i] = 8'(i + 1);
            mem2[i] = 8'(i + 2);
            mem3[i] = 8'(i + 3);
        end
        vecs[0] = '{11'd0,    12'd4,   0, 3, 7, 1'b0};
        vecs[1] = '{11'd1568, 12'd288, 1, 3, 0, 1'b0};
        vecs[2] = '{11'd0,    12'd0,   0, 0, 1, 1'b0};
        vecs[3] = '{11'd2047, 12'd2,   0, 3, 5, 1'b0};
        vecs[4] = '{11'd100,  12'd7,   2, 3, 0, 1'b0};
        vecs[5] = '{11'd200,  12'd5,   0, 3, 8, 1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        dout_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i]);
            tick();
        end

        // Reset three beats into a 10-word transfer discards everything.
        load_expect(11'd0, 12'd10);
        acc0       = accepted_cnt;
        start      = 1'b1;
        base_addr  = 11'd0;
        length     = 12'd10;
        dout_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            start = 1'b0;
            if ((accepted_cnt - acc0) >= 3) break;
        end
        check("abort_beats", 32'(accepted_cnt - acc0), 32'd3);
        reset = 1'b1;
        tick();
        check_all_zero("abort");
        reset = 1'b0;
        exp_words.delete();
        exp_addrs.delete();
        issued_cnt = accepted_cnt;
        prev_hold  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_late_valid", 32'(dout_valid), 32'd0);
            check("abort_idle", 32'(busy | done), 32'd0);
        end
        cv = '{11'd5, 12'd1, 0, 3, 4, 1'b0};
        run_xfer(cv);
        tick();

`ifdef READBACK_CHECKSUM_EN
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = 8'hFF;
            mem1[i] = 8'hFF;
            mem2[i] = 8'hFF;
            mem3[i] = 8'hFF;
        end
        cv = '{11'd0, 12'd16, 0, 3, 19, 1'b0};
        run_xfer(cv);
        check("csum", 32'(csum), 32'h3FC0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/res_readback.md
Name: res_readback

Overview:
- Read-side counterpart of the host load path in mem_top.
- After inference, the host pulls the pooling results out of the four result RAMs (res_ram0..3) through this block.
- Each beat packs one address's four bytes into a 32-bit word, in the same byte order the host uses when writing image words.
- Addresses are generated sequentially from a start address. Reads are prefetched into a 2-entry skid FIFO so a ready-always consumer gets one word per cycle.

Parameters:
- ADDR_W, 11, result RAM address width (depth 2048; layer12 region 0..1567, layer34 region 1568..1855).
- LEN_W, 12, width of the word-count field.
- RAM_LAT, 1, result RAM read latency in cycles; only 1 is supported.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a readback; ignored unless state is IDLE or DONE.
- base_addr  in  ADDR_W  first RAM address; sampled on start.
- length  in  LEN_W  number of words to return; sampled on start.
- res_rd_en  out  1  result RAM read strobe.
- res_addr  out  ADDR_W  result RAM address.
- res_q0, res_q1, res_q2, res_q3  in  8 each  result RAM outputs, valid RAM_LAT cycles after res_rd_en.
- dout  out  32  {res_q0, res_q1, res_q2, res_q3}; res_q0 occupies bits 31:24.
- dout_valid  out  1  FIFO head is valid.
- dout_ready  in  1  consumer accepts the head when dout_valid && dout_ready.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  high in DONE until the next start or reset.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE; FIFO emptied; in-flight flag cleared.
  - res_rd_en = 0, res_addr = 0, dout = 0, dout_valid = 0, busy = 0, done = 0.
  - Reset mid-transfer discards all pending data; a late RAM response is not captured.
- States:
  - IDLE: on start with length != 0, latch addr = base_addr and remaining = length, then go to FETCH. On start with length == 0, go to DONE directly.
  - FETCH: issue reads while remaining > 0.
  - DRAIN: remaining == 0; wait for the FIFO to empty and any in-flight read to land.
  - DONE: on start, behaves exactly as IDLE.
- Read issue rule:
  - res_rd_en = 1 in a cycle iff state == FETCH && remaining > 0 && (fifo_count + inflight − pop) < 2, where pop = dout_valid && dout_ready in the same cycle.
  - On issue: res_addr = addr, addr increments by 1 (wrapping at 2^ADDR_W), remaining decrements by 1.
  - When remaining reaches 0, the next state is DRAIN.
- Capture:
  - The cycle after res_rd_en, res_q0..3 are pushed into the FIFO tail.
  - The FIFO never overflows; this is guaranteed by the issue rule.
- Output:
  - dout and dout_valid come straight from the FIFO head, with no combinational path from res_q to dout.
  - First-word latency: start at cycle T gives res_rd_en at T+1 and dout_valid at T+3.
  - With dout_ready held high, one word is delivered every cycle after that.
- Simultaneous push and pop: both occur; the count is unchanged.
- Backpressure: while dout_ready is low, dout and dout_valid hold stable and issue stalls once the FIFO plus in-flight count reaches 2.
- DRAIN → DONE: occurs when fifo_count == 0 && !inflight. done rises the cycle after the last word is accepted.
- start while busy: ignored, with no effect on addr or remaining.
- Address wrap: base_addr = 2047 with length = 2 reads 2047 then 0.

Optional Feature:
- Macro READBACK_CHECKSUM_EN.
- Defined:
  - Adds output port csum (16 bits), cleared on reset and on an accepted start.
  - On each accepted output beat, csum += the sum of the four bytes, modulo 2^16.
  - Updates one cycle after the beat; final value is valid when done rises.
- Undefined: the port and all checksum logic are absent; all other behaviour is identical.

Test Plan:
- Preload mem[i] of ram0..3 = {i[7:0], i[7:0]+1, i[7:0]+2, i[7:0]+3}. start with base=0, length=4, dout_ready=1 → dout = 00010203, 01020304, 02030405, 03040506 on consecutive cycles; first dout_valid at start+3; done at start+7.
- Same preload; base=1568, length=288, dout_ready toggles 1,0,0,1 → exactly 288 beats in address order; no duplicates or drops; res_rd_en never fires while FIFO plus in-flight equals 2.
- length=0 → res_rd_en never asserted; done = 1 the cycle after start; dout_valid stays 0.
- base=2047, length=2 → res_addr sequence 2047 then 0; dout = mem[2047] word then mem[0] word.
- Assert reset 3 beats into a length=10 transfer → next cycle all outputs 0 and state IDLE. A following start with base=5, length=1 returns mem[5] only.
- With READBACK_CHECKSUM_EN defined: all four RAMs filled with 0xFF, length=16 → csum = 16·4·255 mod 65536 = 0x3FC0 when done rises.
